// File: rtl/rgb_proc_pipe.sv
// Two-stage RGB colour pipeline (colour mode, then saturating brightener) with valid/ready.
// Define RGB_PROC_SAT_STATS_EN to build the per-frame clipped-pixel counter behind sat_cnt_o.
module rgb_proc_pipe #(
    parameter int unsigned PIX_W      = 8,
    parameter int unsigned POST_BITS  = 2,
    parameter int unsigned BRIGHT_OFS = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [2:0]       switch_i,
    input  logic [PIX_W-1:0] r_i,
    input  logic [PIX_W-1:0] g_i,
    input  logic [PIX_W-1:0] b_i,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic             vde_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [PIX_W-1:0] r_o,
    output logic [PIX_W-1:0] g_o,
    output logic [PIX_W-1:0] b_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             vde_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [31:0]      sat_cnt_o
);

    localparam int unsigned      GW        = PIX_W + 8;
    localparam logic [1:0]       MODE_PASS = 2'b00;
    localparam logic [1:0]       MODE_POST = 2'b01;
    localparam logic [1:0]       MODE_INV  = 2'b10;
    localparam logic [1:0]       MODE_GRAY = 2'b11;
    localparam logic [PIX_W-1:0] PIX_MAX   = '1;
    localparam logic [PIX_W-1:0] POST_MASK = ~(PIX_MAX >> POST_BITS);
    localparam logic [PIX_W:0]   OFS       = (PIX_W + 1)'(BRIGHT_OFS);
    localparam logic [GW-1:0]    K_R       = GW'(77);
    localparam logic [GW-1:0]    K_G       = GW'(150);
    localparam logic [GW-1:0]    K_B       = GW'(29);

    function automatic logic [PIX_W-1:0] f_colour(input logic [1:0]       mode,
                                                  input logic [PIX_W-1:0] x,
                                                  input logic [PIX_W-1:0] gray);
        logic [PIX_W-1:0] y;
        unique case (mode)
            MODE_PASS: y = x;
            MODE_POST: y = x & POST_MASK;
            MODE_INV:  y = ~x;
            MODE_GRAY: y = gray;
            default:   y = x;
        endcase
        return y;
    endfunction

    function automatic logic [PIX_W:0] f_add(input logic [PIX_W-1:0] x);
        return {1'b0, x} + OFS;
    endfunction

    function automatic logic [PIX_W-1:0] f_bright(input logic en, input logic [PIX_W-1:0] x);
        logic [PIX_W:0] sum;
        sum = f_add(x);
        if (!en) begin
            return x;
        end
        return sum[PIX_W] ? PIX_MAX : sum[PIX_W-1:0];
    endfunction

    // Handshake
    logic w_s2_ready;
    logic w_s1_ready;
    logic w_accept;
    logic w_vs_rise;
    logic [2:0] w_mode_eff;

    logic             r_s1_valid;
    logic [PIX_W-1:0] r_s1_r, r_s1_g, r_s1_b;
    logic             r_s1_hs, r_s1_vs, r_s1_de;
    logic             r_s1_bright;

    logic             r_s2_valid;
    logic [PIX_W-1:0] r_s2_r, r_s2_g, r_s2_b;
    logic             r_s2_hs, r_s2_vs, r_s2_de;

    logic [2:0] r_mode;
    logic       r_vs_prev;

    assign w_s2_ready = !r_s2_valid || ready_i;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;
    assign ready_o    = w_s1_ready;
    assign w_accept   = valid_i && w_s1_ready;
    assign w_vs_rise  = vsync_i && !r_vs_prev;

    // The frame-start beat itself already uses the newly requested mode.
    assign w_mode_eff = (w_accept && w_vs_rise) ? switch_i : r_mode;

    // S1 colour mode
    logic [GW-1:0]    w_gray_sum;
    logic [PIX_W-1:0] w_gray;
    logic             w_unused_gray;
    logic [PIX_W-1:0] w_c_r, w_c_g, w_c_b;

    assign w_gray_sum    = K_R * GW'(r_i) + K_G * GW'(g_i) + K_B * GW'(b_i);
    assign w_gray        = w_gray_sum[GW-1:8];
    assign w_unused_gray = ^w_gray_sum[7:0];

    assign w_c_r = f_colour(w_mode_eff[1:0], r_i, w_gray);
    assign w_c_g = f_colour(w_mode_eff[1:0], g_i, w_gray);
    assign w_c_b = f_colour(w_mode_eff[1:0], b_i, w_gray);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid  <= 1'b0;
            r_s1_r      <= '0;
            r_s1_g      <= '0;
            r_s1_b      <= '0;
            r_s1_hs     <= 1'b0;
            r_s1_vs     <= 1'b0;
            r_s1_de     <= 1'b0;
            r_s1_bright <= 1'b0;
            r_mode      <= 3'b000;
            r_vs_prev   <= 1'b0;
        end else begin
            if (w_s1_ready) begin
                r_s1_valid <= valid_i;
            end
            if (w_accept) begin
                r_s1_r      <= w_c_r;
                r_s1_g      <= w_c_g;
                r_s1_b      <= w_c_b;
                r_s1_hs     <= hsync_i;
                r_s1_vs     <= vsync_i;
                r_s1_de     <= vde_i;
                r_s1_bright <= w_mode_eff[2];
                r_vs_prev   <= vsync_i;
                if (w_vs_rise) begin
                    r_mode <= switch_i;
                end
            end
        end
    end

    // S2 brightener, using the brighten bit captured with the beat
    logic [PIX_W-1:0] w_s2_r, w_s2_g, w_s2_b;

    assign w_s2_r = f_bright(r_s1_bright, r_s1_r);
    assign w_s2_g = f_bright(r_s1_bright, r_s1_g);
    assign w_s2_b = f_bright(r_s1_bright, r_s1_b);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_valid <= 1'b0;
            r_s2_r     <= '0;
            r_s2_g     <= '0;
            r_s2_b     <= '0;
            r_s2_hs    <= 1'b0;
            r_s2_vs    <= 1'b0;
            r_s2_de    <= 1'b0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_r  <= w_s2_r;
                r_s2_g  <= w_s2_g;
                r_s2_b  <= w_s2_b;
                r_s2_hs <= r_s1_hs;
                r_s2_vs <= r_s1_vs;
                r_s2_de <= r_s1_de;
            end
        end
    end

    assign valid_o = r_s2_valid;
    assign r_o     = r_s2_r;
    assign g_o     = r_s2_g;
    assign b_o     = r_s2_b;
    assign hsync_o = r_s2_hs;
    assign vsync_o = r_s2_vs;
    assign vde_o   = r_s2_de;

`ifdef RGB_PROC_SAT_STATS_EN
    logic [PIX_W:0] w_sum_r, w_sum_g, w_sum_b;
    logic           w_s2_sat;
    logic           w_out_fire;
    logic           r_s2_sat;
    logic           r_out_vs_prev;
    logic [31:0]    r_sat_cnt;
    logic [31:0]    r_sat_last;

    assign w_sum_r    = f_add(r_s1_r);
    assign w_sum_g    = f_add(r_s1_g);
    assign w_sum_b    = f_add(r_s1_b);
    assign w_s2_sat   = r_s1_bright && (w_sum_r[PIX_W] || w_sum_g[PIX_W] || w_sum_b[PIX_W]);
    assign w_out_fire = r_s2_valid && ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_sat      <= 1'b0;
            r_out_vs_prev <= 1'b0;
            r_sat_cnt     <= '0;
            r_sat_last    <= '0;
        end else begin
            if (w_s2_ready && r_s1_valid) begin
                r_s2_sat <= w_s2_sat;
            end
            if (w_out_fire) begin
                r_out_vs_prev <= r_s2_vs;
                // A new frame publishes the finished count and restarts with this beat.
                if (r_s2_vs && !r_out_vs_prev) begin
                    r_sat_last <= r_sat_cnt;
                    r_sat_cnt  <= {31'd0, r_s2_de && r_s2_sat};
                end else if (r_s2_de && r_s2_sat && (r_sat_cnt != '1)) begin
                    r_sat_cnt <= r_sat_cnt + 32'd1;
                end
            end
        end
    end

    assign sat_cnt_o = r_sat_last;
`else
    assign sat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rgb_proc_pipe.sv
// Directed and scoreboard bench for rgb_proc_pipe (default parameters: 8-bit, 2 posterize bits, +64).
module tb_rgb_proc_pipe;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic [2:0] switch_i;
    logic [7:0] r_i, g_i, b_i;
    logic       hsync_i, vsync_i, vde_i, valid_i;
    logic       ready_o;
    logic [7:0] r_o, g_o, b_o;
    logic       hsync_o, vsync_o, vde_o, valid_o;
    logic       ready_i;
    logic [31:0] sat_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rgb_proc_pipe dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .switch_i  (switch_i),
        .r_i       (r_i),
        .g_i       (g_i),
        .b_i       (b_i),
        .hsync_i   (hsync_i),
        .vsync_i   (vsync_i),
        .vde_i     (vde_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .r_o       (r_o),
        .g_o       (g_o),
        .b_o       (b_o),
        .hsync_o   (hsync_o),
        .vsync_o   (vsync_o),
        .vde_o     (vde_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .sat_cnt_o (sat_cnt_o)
    );

    // Independent reference for one accepted pixel under mode m.
    function automatic logic [23:0] model_pix(input logic [2:0] m, input logic [7:0] r,
                                              input logic [7:0] g, input logic [7:0] b);
        int ch [3];
        int gray;
        int x;
        logic [23:0] res;
        gray = (77 * int'(r) + 150 * int'(g) + 29 * int'(b)) / 256;
        ch[0] = int'(r);
        ch[1] = int'(g);
        ch[2] = int'(b);
        for (int i = 0; i < 3; i++) begin
            x = ch[i];
            case (m[1:0])
                2'd0: x = x;
                2'd1: x = (x / 64) * 64;
                2'd2: x = 255 - x;
                default: x = gray;
            endcase
            if (m[2]) x = (x + 64 > 255) ? 255 : x + 64;
            ch[i] = x;
        end
        res = {ch[0][7:0], ch[1][7:0], ch[2][7:0]};
        return res;
    endfunction

    // One accepted beat, entered and left at posedge+1.
    task automatic send_beat(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                             input logic hs, input logic vs, input logic de,
                             input logic [2:0] sw);
        int cnt = 0;
        r_i = r; g_i = g; b_i = b;
        hsync_i = hs; vsync_i = vs; vde_i = de; switch_i = sw;
        valid_i = 1'b1;
        while (!ready_o && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (!ready_o) begin
            n_checks++; n_fail++;
            $display("FAIL send_beat: ready_o stuck at %0b, required 1", ready_o);
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    // Waits for the next output beat, captures it, and lets it handshake (ready_i assumed 1).
    task automatic get_out(output logic [7:0] r, output logic [7:0] g, output logic [7:0] b,
                           output logic hs, output logic vs, output logic de);
        logic ok = 1'b0;
        r = '0; g = '0; b = '0; hs = 1'b0; vs = 1'b0; de = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (valid_o) begin
                r = r_o; g = g_o; b = b_o; hs = hsync_o; vs = vsync_o; de = vde_o;
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL get_out: valid_o never rose within 20 cycles");
        end
    endtask

    task automatic vs_low(input logic [2:0] sw);
        logic [7:0] r, g, b;
        logic hs, vs, de;
        send_beat(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, sw);
        get_out(r, g, b, hs, vs, de);
    endtask

    task automatic test_reset();
        valid_i = 0; ready_i = 1; switch_i = 0;
        r_i = 0; g_i = 0; b_i = 0; hsync_i = 0; vsync_i = 0; vde_i = 0;
        #3;
        n_checks++;
        if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %0b, required 0", valid_o);
        end
        n_checks++;
        if (ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %0b, required 1", ready_o);
        end
        n_checks++;
        if ({r_o, g_o, b_o, hsync_o, vsync_o, vde_o} !== 27'd0) begin
            n_fail++; $display("FAIL reset_data: got %h, required 0",
                               {r_o, g_o, b_o, hsync_o, vsync_o, vde_o});
        end
        n_checks++;
        if (sat_cnt_o !== 32'd0) begin
            n_fail++; $display("FAIL reset_sat_cnt: got %0d, required 0", sat_cnt_o);
        end
        #9 rst_ni = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_passthrough();
        r_i = 8'd200; g_i = 8'd100; b_i = 8'd50;
        hsync_i = 1; vsync_i = 1; vde_i = 1; switch_i = 3'b000; valid_i = 1;
        n_checks++;
        if (ready_o !== 1'b1) begin
            n_fail++; $display("FAIL pass_accept: ready_o %0b, required 1", ready_o);
        end
        @(posedge clk); #1;
        valid_i = 0;
        n_checks++;
        if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL pass_latency1: valid_o %0b, required 0", valid_o);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({valid_o, r_o, g_o, b_o, hsync_o, vsync_o, vde_o} !==
            {1'b1, 8'd200, 8'd100, 8'd50, 3'b111}) begin
            n_fail++; $display("FAIL pass_out: got v=%0b %0d,%0d,%0d sb=%b, required 1 200,100,50 111",
                               valid_o, r_o, g_o, b_o, {hsync_o, vsync_o, vde_o});
        end
        @(posedge clk); #1;
        n_checks++;
        if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL pass_single: valid_o %0b after handshake, required 0", valid_o);
        end
    endtask

    task automatic test_gray_latch();
        logic [7:0] r, g, b;
        logic hs, vs, de;
        vs_low(3'b000);
        send_beat(8'd255, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 3'b011);
        get_out(r, g, b, hs, vs, de);
        n_checks++;
        if ({r, g, b} !== {8'd76, 8'd76, 8'd76}) begin
            n_fail++; $display("FAIL gray_red: got %0d,%0d,%0d, required 76,76,76", r, g, b);
        end
        send_beat(8'd100, 8'd50, 8'd200, 1'b1, 1'b1, 1'b1, 3'b010);
        get_out(r, g, b, hs, vs, de);
        n_checks++;
        if ({r, g, b, hs} !== {8'd82, 8'd82, 8'd82, 1'b1}) begin
            n_fail++; $display("FAIL gray_midframe: got %0d,%0d,%0d hs=%0b, required 82,82,82 hs=1",
                               r, g, b, hs);
        end
        vs_low(3'b010);
        send_beat(8'd255, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 3'b010);
        get_out(r, g, b, hs, vs, de);
        n_checks++;
        if ({r, g, b} !== {8'd0, 8'd255, 8'd255}) begin
            n_fail++; $display("FAIL invert_newframe: got %0d,%0d,%0d, required 0,255,255", r, g, b);
        end
    endtask

    task automatic test_posterize_brighten();
        logic [7:0] r, g, b;
        logic hs, vs, de;
        vs_low(3'b000);
        send_beat(8'hB7, 8'h6C, 8'h3F, 1'b0, 1'b1, 1'b1, 3'b001);
        get_out(r, g, b, hs, vs, de);
        n_checks++;
        if ({r, g, b} !== {8'h80, 8'h40, 8'h00}) begin
            n_fail++; $display("FAIL posterize: got %h,%h,%h, required 80,40,00", r, g, b);
        end
        vs_low(3'b000);
        send_beat(8'd0, 8'd200, 8'd255, 1'b0, 1'b1, 1'b1, 3'b110);
        get_out(r, g, b, hs, vs, de);
        n_checks++;
        if ({r, g, b} !== {8'd255, 8'd119, 8'd64}) begin
            n_fail++; $display("FAIL invert_bright: got %0d,%0d,%0d, required 255,119,64", r, g, b);
        end
        vs_low(3'b000);
        send_beat(8'd191, 8'd192, 8'd10, 1'b0, 1'b1, 1'b1, 3'b100);
        get_out(r, g, b, hs, vs, de);
        n_checks++;
        if ({r, g, b} !== {8'd255, 8'd255, 8'd74}) begin
            n_fail++; $display("FAIL bright_edge: got %0d,%0d,%0d, required 255,255,74", r, g, b);
        end
    endtask

    task automatic test_backpressure();
        vs_low(3'b000);
        ready_i = 0;
        r_i = 8'd1; g_i = 8'd2; b_i = 8'd3; hsync_i = 0; vsync_i = 1; vde_i = 1;
        switch_i = 3'b000; valid_i = 1;
        @(posedge clk); #1;
        r_i = 8'd4; g_i = 8'd5; b_i = 8'd6;
        n_checks++;
        if (ready_o !== 1'b1) begin
            n_fail++; $display("FAIL bp_second_accept: ready_o %0b, required 1", ready_o);
        end
        @(posedge clk); #1;
        r_i = 8'd7; g_i = 8'd8; b_i = 8'd9;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({ready_o, valid_o, r_o, g_o, b_o} !== {1'b0, 1'b1, 8'd1, 8'd2, 8'd3}) begin
                n_fail++; $display("FAIL bp_hold%0d: rdy=%0b v=%0b %0d,%0d,%0d, required 0 1 1,2,3",
                                   i, ready_o, valid_o, r_o, g_o, b_o);
            end
            if (i < 4) begin
                @(posedge clk); #1;
            end
        end
        ready_i = 1;
        @(posedge clk); #1;
        valid_i = 0;
        n_checks++;
        if ({valid_o, r_o, g_o, b_o} !== {1'b1, 8'd4, 8'd5, 8'd6}) begin
            n_fail++; $display("FAIL bp_second_out: v=%0b %0d,%0d,%0d, required 1 4,5,6",
                               valid_o, r_o, g_o, b_o);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({valid_o, r_o, g_o, b_o} !== {1'b1, 8'd7, 8'd8, 8'd9}) begin
            n_fail++; $display("FAIL bp_third_out: v=%0b %0d,%0d,%0d, required 1 7,8,9",
                               valid_o, r_o, g_o, b_o);
        end
        @(posedge clk); #1;
        n_checks++;
        if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_drained: valid_o %0b, required 0", valid_o);
        end
    endtask

    task automatic test_random_scoreboard();
        logic [26:0] q[$];
        logic [26:0] exp_beat, cur_out, prev_out;
        logic [2:0]  m_mode = 3'b000;
        logic        m_vs_prev = 1'b0;
        logic        acc, fire, hold_prev;
        int          n_acc = 0;
        int          drain = 0;
        int          cyc = 0;
        rst_ni = 1'b0;
        #2 rst_ni = 1'b1;
        @(posedge clk); #1;
        hold_prev = 1'b0;
        prev_out = '0;
        while (cyc < 20000 && drain < 8) begin
            cyc++;
            r_i = 8'($urandom); g_i = 8'($urandom); b_i = 8'($urandom);
            hsync_i = 1'($urandom); vde_i = 1'($urandom);
            vsync_i = ($urandom_range(0, 5) == 0);
            switch_i = 3'($urandom);
            valid_i = (n_acc < 1000) && ($urandom_range(0, 3) != 0);
            ready_i = (n_acc >= 1000) || ($urandom_range(0, 2) != 0);
            #1;
            acc = valid_i && ready_o;
            fire = valid_o && ready_i;
            cur_out = {r_o, g_o, b_o, hsync_o, vsync_o, vde_o};
            if (hold_prev) begin
                n_checks++;
                if (!valid_o || cur_out !== prev_out) begin
                    n_fail++; $display("FAIL sb_stall_stable: v=%0b out=%h, required 1 %h",
                                       valid_o, cur_out, prev_out);
                end
            end
            hold_prev = valid_o && !ready_i;
            prev_out = cur_out;
            @(posedge clk);
            if (fire) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL sb_extra: unexpected beat %h, required none", cur_out);
                end else begin
                    exp_beat = q.pop_front();
                    if (cur_out !== exp_beat) begin
                        n_fail++; $display("FAIL sb_data: got %h, required %h", cur_out, exp_beat);
                    end
                end
            end
            if (acc) begin
                if (vsync_i && !m_vs_prev) m_mode = switch_i;
                m_vs_prev = vsync_i;
                q.push_back({model_pix(m_mode, r_i, g_i, b_i), hsync_i, vsync_i, vde_i});
                n_acc++;
            end
            if (n_acc >= 1000 && q.size() == 0) drain++;
            #1;
        end
        valid_i = 0;
        ready_i = 1;
        n_checks++;
        if (q.size() != 0 || n_acc < 1000) begin
            n_fail++; $display("FAIL sb_complete: %0d pending, %0d accepted, required 0 and 1000",
                               q.size(), n_acc);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] r, g, b;
        logic hs, vs, de;
        vs_low(3'b000);
        send_beat(8'd1, 8'd1, 8'd1, 1'b0, 1'b1, 1'b1, 3'b010);
        get_out(r, g, b, hs, vs, de);
        ready_i = 0;
        r_i = 8'd9; g_i = 8'd9; b_i = 8'd9; vsync_i = 1; vde_i = 1; valid_i = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({valid_o, ready_o, r_o, vsync_o} !== {1'b0, 1'b1, 8'd0, 1'b0}) begin
            n_fail++; $display("FAIL areset_immediate: v=%0b rdy=%0b r=%0d vs=%0b, required 0 1 0 0",
                               valid_o, ready_o, r_o, vsync_o);
        end
        valid_i = 0;
        ready_i = 1;
        #2 rst_ni = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL areset_empty: valid_o %0b, required 0", valid_o);
        end
        send_beat(8'd10, 8'd20, 8'd30, 1'b0, 1'b0, 1'b1, 3'b010);
        get_out(r, g, b, hs, vs, de);
        n_checks++;
        if ({r, g, b} !== {8'd10, 8'd20, 8'd30}) begin
            n_fail++; $display("FAIL areset_pass: got %0d,%0d,%0d, required 10,20,30", r, g, b);
        end
        send_beat(8'd10, 8'd20, 8'd30, 1'b0, 1'b1, 1'b1, 3'b010);
        get_out(r, g, b, hs, vs, de);
        n_checks++;
        if ({r, g, b} !== {8'd245, 8'd235, 8'd225}) begin
            n_fail++; $display("FAIL areset_newmode: got %0d,%0d,%0d, required 245,235,225", r, g, b);
        end
    endtask

    task automatic test_sat_stats();
        logic [7:0] r, g, b;
        logic hs, vs, de;
        logic [31:0] exp_cnt;
`ifdef RGB_PROC_SAT_STATS_EN
        exp_cnt = 32'd3;
`else
        exp_cnt = 32'd0;
`endif
        vs_low(3'b000);
        for (int i = 0; i < 10; i++) begin
            if (i == 0 || i == 4 || i == 9) begin
                send_beat(8'd250, 8'd10, 8'd10, 1'b0, 1'b1, 1'b1, 3'b100);
            end else begin
                send_beat(8'd10, 8'd10, 8'd10, 1'b0, 1'b1, 1'b1, 3'b100);
            end
            get_out(r, g, b, hs, vs, de);
        end
        send_beat(8'd255, 8'd255, 8'd255, 1'b0, 1'b1, 1'b0, 3'b100);
        get_out(r, g, b, hs, vs, de);
        n_checks++;
        if ({r, g, b} !== {8'd255, 8'd255, 8'd255}) begin
            n_fail++; $display("FAIL sat_blank_pix: got %0d,%0d,%0d, required 255,255,255", r, g, b);
        end
        vs_low(3'b100);
        send_beat(8'd10, 8'd10, 8'd10, 1'b0, 1'b1, 1'b1, 3'b100);
        get_out(r, g, b, hs, vs, de);
        n_checks++;
        if (sat_cnt_o !== exp_cnt) begin
            n_fail++; $display("FAIL sat_cnt: got %0d, required %0d", sat_cnt_o, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_gray_latch();
        test_posterize_brighten();
        test_backpressure();
        test_random_scoreboard();
        test_async_reset();
        test_sat_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
